// File: rtl/switch_debounce.sv
// Four-bit slide-switch debouncer with per-bit synchronizers, stable-count
// filtering, registered edge pulses and a synchronized reset release.
module switch_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] swt,
   output logic [3:0] swt_db,
   output logic [3:0] rise,
   output logic [3:0] fall,
   output logic       all_on,
   output logic       any_edge
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]         rst_q;
   logic               rst_i;
   logic [3:0]         s1;
   logic [3:0]         s2;
   logic [3:0]         db;
   logic [3:0]         rise_q;
   logic [3:0]         fall_q;
   logic [3:0][CW-1:0] cnt;

   // Assert asynchronously, release only after two clean clock edges.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_q <= 2'b00;
      end else begin
         rst_q <= {rst_q[0], 1'b1};
      end
   end

   assign rst_i = rst_q[1];

   always_ff @(posedge clk or negedge rst_i) begin
      if (!rst_i) begin
         s1     <= '0;
         s2     <= '0;
         db     <= '0;
         rise_q <= '0;
         fall_q <= '0;
         cnt    <= '0;
      end else begin
         s1     <= swt;
         s2     <= s1;
         rise_q <= '0;
         fall_q <= '0;
         for (int i = 0; i < 4; i++) begin
            if (s2[i] == db[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == TERM) begin
               db[i]     <= s2[i];
               cnt[i]    <= '0;
               rise_q[i] <= s2[i];
               fall_q[i] <= ~s2[i];
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

   assign swt_db   = db;
   assign rise     = rise_q;
   assign fall     = fall_q;
   assign all_on   = &db;
   assign any_edge = |(rise_q | fall_q);

endmodule

// File: tb/tb_switch_debounce.sv
// Scoreboard bench for switch_debounce: directed vectors followed by a
// bounce phase checked against a behavioural model.
module tb_switch_debounce;

   localparam int D = 4;

   typedef struct {
      int         cyc;
      logic [3:0] db;
      logic [3:0] r;
      logic [3:0] f;
   } ev_t;

   logic       clk;
   logic       rst_n;
   logic [3:0] swt;
   logic [3:0] swt_db;
   logic [3:0] rise;
   logic [3:0] fall;
   logic       all_on;
   logic       any_edge;

   int  cyc;
   int  vectors;
   int  errs;
   ev_t q[$];

   bit         mdl_on;
   logic [3:0] m_s1;
   logic [3:0] m_s2;
   logic [3:0] m_db;
   int         m_cnt[4];

   switch_debounce #(.DEBOUNCE_CYCLES(D)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .swt      (swt),
      .swt_db   (swt_db),
      .rise     (rise),
      .fall     (fall),
      .all_on   (all_on),
      .any_edge (any_edge)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s cyc=%0d got=%0h required=%0h", nm, cyc, act, exp);
      end
   endtask

   task automatic wait_to(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_db"}, {28'd0, swt_db}, 32'd0);
      chk({nm, "_rise"}, {28'd0, rise}, 32'd0);
      chk({nm, "_fall"}, {28'd0, fall}, 32'd0);
      chk({nm, "_all_on"}, {31'd0, all_on}, 32'd0);
      chk({nm, "_any_edge"}, {31'd0, any_edge}, 32'd0);
   endtask

   // Cycle counter plus behavioural model of the debounce filter.
   always @(posedge clk) begin
      logic [3:0] r;
      logic [3:0] f;
      cyc++;
      if (mdl_on) begin
         r = '0;
         f = '0;
         for (int i = 0; i < 4; i++) begin
            if (m_s2[i] == m_db[i]) begin
               m_cnt[i] = 0;
            end else if (m_cnt[i] == D - 1) begin
               m_db[i]  = m_s2[i];
               m_cnt[i] = 0;
               r[i]     = m_s2[i];
               f[i]     = ~m_s2[i];
            end else begin
               m_cnt[i]++;
            end
         end
         m_s2 = m_s1;
         m_s1 = swt;
         if ((r | f) != 4'd0) q.push_back('{cyc, m_db, r, f});
      end
   end

   // Monitor: every presented edge pops one expected event.
   always @(negedge clk) begin
      ev_t e;
      if ((rise & fall) != 4'd0) chk("rise_and_fall", {28'd0, rise & fall}, 32'd0);
      if (any_edge) begin
         if (q.size() == 0) begin
            vectors++;
            errs++;
            $display("FAIL unexpected_edge cyc=%0d got rise=%b fall=%b required none",
                     cyc, rise, fall);
         end else begin
            e = q.pop_front();
            chk("ev_cycle", cyc, e.cyc);
            chk("ev_db", {28'd0, swt_db}, {28'd0, e.db});
            chk("ev_rise", {28'd0, rise}, {28'd0, e.r});
            chk("ev_fall", {28'd0, fall}, {28'd0, e.f});
         end
      end else if (q.size() != 0 && q[0].cyc < cyc) begin
         e = q.pop_front();
         vectors++;
         errs++;
         $display("FAIL missing_edge cyc=%0d got none required rise=%b fall=%b at cyc %0d",
                  cyc, e.r, e.f, e.cyc);
      end
      if (mdl_on) chk("model_db", {28'd0, swt_db}, {28'd0, m_db});
   end

   initial begin
      int         run[4];
      logic [3:0] nxt;
      cyc     = 0;
      vectors = 0;
      errs    = 0;
      mdl_on  = 1'b0;
      swt     = 4'hF;
      rst_n   = 1'b1;
      #1 rst_n = 1'b0;
      #1 chk_zero("reset_t0");
      wait_to(1);
      chk_zero("reset_held");
      wait_to(2);
      swt   = 4'h0;
      rst_n = 1'b1;

      // Single bit rises: sampled at edge 10, debounced at edge 15.
      wait_to(9);
      swt = 4'b0001;
      q.push_back('{15, 4'b0001, 4'b0001, 4'b0000});
      wait_to(14);
      chk("pre_latency_db", {28'd0, swt_db}, 32'd0);
      wait_to(16);
      chk("rise_one_cycle", {28'd0, rise}, 32'd0);
      chk("hold_db", {28'd0, swt_db}, 32'd1);

      // Bit 2 bounces: 3 high, 1 low, 3 high, then low -- never accepted.
      wait_to(20);
      swt = 4'b0101;
      wait_to(23);
      swt = 4'b0001;
      wait_to(24);
      swt = 4'b0101;
      wait_to(27);
      swt = 4'b0001;
      wait_to(30);
      swt = 4'b0000;
      q.push_back('{36, 4'b0000, 4'b0000, 4'b0001});
      wait_to(39);
      chk("glitch_db", {28'd0, swt_db}, 32'd0);

      // All four together, then drop bit 3.
      wait_to(40);
      swt = 4'b1111;
      q.push_back('{46, 4'b1111, 4'b1111, 4'b0000});
      wait_to(45);
      chk("all_on_before", {31'd0, all_on}, 32'd0);
      wait_to(47);
      chk("all_on_set", {31'd0, all_on}, 32'd1);
      chk("any_edge_once", {31'd0, any_edge}, 32'd0);
      wait_to(50);
      swt = 4'b0111;
      q.push_back('{56, 4'b0111, 4'b0000, 4'b1000});
      wait_to(57);
      chk("all_on_clear", {31'd0, all_on}, 32'd0);

      // Bit 1 falls, then its rise is cut off by a reset mid-count.
      wait_to(60);
      swt = 4'b0101;
      q.push_back('{66, 4'b0101, 4'b0000, 4'b0010});
      wait_to(70);
      swt = 4'b0111;
      wait_to(74);
      rst_n = 1'b0;
      #1 chk_zero("reset_mid");
      wait_to(77);
      chk_zero("reset_mid_held");
      wait_to(78);
      rst_n = 1'b1;
      q.push_back('{86, 4'b0111, 4'b0111, 4'b0000});
      wait_to(85);
      chk("post_reset_pre", {28'd0, swt_db}, 32'd0);
      wait_to(87);
      chk("post_reset_db", {28'd0, swt_db}, 32'h7);

      // Random bounce checked against the model every cycle.
      wait_to(100);
      m_s1   = swt;
      m_s2   = swt;
      m_db   = swt;
      for (int i = 0; i < 4; i++) begin
         m_cnt[i] = 0;
         run[i]   = $urandom_range(1, 9);
      end
      mdl_on = 1'b1;
      for (int n = 0; n < 600; n++) begin
         @(negedge clk);
         nxt = swt;
         for (int i = 0; i < 4; i++) begin
            run[i]--;
            if (run[i] <= 0) begin
               nxt[i] = ~nxt[i];
               run[i] = $urandom_range(1, 9);
            end
         end
         swt = nxt;
      end
      repeat (D + 8) @(negedge clk);
      mdl_on = 1'b0;
      @(negedge clk);
      chk("queue_empty", q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
